led_pattern_controller: RTL and testbench

Sequencer for the 8-LED board's light patterns. It takes three raw push-buttons (start/pause, mode, speed), debounces them, and runs a RUN/PAUSE/IDLE state machine. Patterns advance on a programmable tick derived from the board clock. It drives the LED bank directly and replaces ad-hoc per-pattern modules at the top level.

---
 rtl/led_ctrl_pkg.sv | 26 ++
 rtl/button_debounce.sv | 50 +++++
 rtl/led_pattern_controller.sv | 156 +++++++++++++++
 tb/tb_led_pattern_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and constants for the LED pattern sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_SHL    = 2'd0,
        MD_SHR    = 2'd1,
        MD_BOUNCE = 2'd2,
        MD_BLINK  = 2'd3
    } mode_e;

    localparam logic [7:0] BLINK_A = 8'h55;
    localparam logic [7:0] BLINK_B = 8'hAA;

    localparam int unsigned SPEED_W = 2;

    function automatic logic [7:0] onehot8(input logic [2:0] p);
        return 8'h01 << p;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button to single-cycle press pulse: 2-flop sync, stability
// counter and rising-edge detect on the accepted level.
module button_debounce #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0]  sync_q;
    logic        level_q, level_d;
    logic [31:0] cnt_q, cnt_d;
    logic        press_q, press_d;
    logic        differs;
    logic        accept;

    always_comb begin
        differs = sync_q[1] != level_q;
        accept  = differs && (cnt_q == DEBOUNCE_CYCLES - 32'd1);
        cnt_d   = cnt_q + 32'd1;
        level_d = level_q;
        press_d = 1'b0;
        if (!differs || accept) begin
            cnt_d = 32'd0;
        end
        if (accept) begin
            level_d = sync_q[1];
            press_d = sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= 32'd0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_pattern_controller.sv
// 8-LED pattern sequencer: debounced buttons drive an IDLE/RUN/PAUSE
// FSM, a speed-scaled step tick and four LED patterns.
module led_pattern_controller
    import led_ctrl_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter logic [31:0] TICK_BASE       = 32'd100_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_start,
    input  logic         btn_mode,
    input  logic         btn_speed,
    output logic [7:0]   led,
    output logic [1:0]   state,
    output logic [1:0]   mode,
    output logic [1:0]   speed
);

    logic start_p, mode_p, speed_p;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .btn_i(btn_start), .press_o(start_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk(clk), .rst(rst), .btn_i(btn_speed), .press_o(speed_p)
    );

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [31:0]          tcnt_q, tcnt_d;
    logic [2:0]           pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic [7:0]           led_q, led_d;

    logic [31:0] period;
    logic        tick;
    logic        step;
    logic        load;
    logic [2:0]  npos;

    assign period = TICK_BASE >> speed_q;
    assign tick   = (state_q == ST_RUN) && (tcnt_q == period - 32'd1);
    assign step   = tick && !start_p && !mode_p && !speed_p;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        tcnt_d  = tcnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        led_d   = led_q;
        load    = 1'b0;
        npos    = 3'd0;

        if (start_p) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (mode_p) begin
            mode_d = mode_e'(mode_q + 2'd1);
            if (state_q != ST_IDLE) begin
                load = 1'b1;
            end
        end

        if (speed_p) begin
            speed_d = speed_q + 2'd1;
        end

        // A pause landing on a tick holds the due step for after resume.
        if (load || speed_p) begin
            tcnt_d = 32'd0;
        end else if (state_q == ST_RUN) begin
            if (tick && start_p) begin
                tcnt_d = tcnt_q;
            end else if (tick) begin
                tcnt_d = 32'd0;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        if (load) begin
            dir_d = 1'b1;
            unique case (mode_d)
                MD_SHL:    begin pos_d = 3'd0; led_d = 8'h01; end
                MD_SHR:    begin pos_d = 3'd7; led_d = 8'h80; end
                MD_BOUNCE: begin pos_d = 3'd0; led_d = 8'h01; end
                MD_BLINK:  begin pos_d = 3'd0; led_d = BLINK_A; end
            endcase
        end else if (step) begin
            unique case (mode_q)
                MD_SHL: begin
                    npos  = pos_q + 3'd1;
                    pos_d = npos;
                    led_d = onehot8(npos);
                end
                MD_SHR: begin
                    npos  = pos_q - 3'd1;
                    pos_d = npos;
                    led_d = onehot8(npos);
                end
                MD_BOUNCE: begin
                    npos  = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;
                    pos_d = npos;
                    led_d = onehot8(npos);
                    if (npos == 3'd7) dir_d = 1'b0;
                    if (npos == 3'd0) dir_d = 1'b1;
                end
                MD_BLINK: begin
                    led_d = (led_q == BLINK_A) ? BLINK_B : BLINK_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MD_SHL;
            speed_q <= '0;
            tcnt_q  <= 32'd0;
            pos_q   <= 3'd0;
            dir_q   <= 1'b1;
            led_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            tcnt_q  <= tcnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign state = state_q;
    assign mode  = mode_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with DEBOUNCE_CYCLES=4,
// TICK_BASE=8; a press is seen 7 edges after the raw level rises.
module tb_led_pattern_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bs = 1'b0;
    logic       bm = 1'b0;
    logic       bsp = 1'b0;
    logic [7:0] led;
    logic [1:0] state;
    logic [1:0] mode;
    logic [1:0] speed;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0, e, r, t, m, b, kk, s1, s2, s3, s4, c;

    logic [7:0] bounce_tab [16] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02
    };

    always #5 clk = ~clk;

    led_pattern_controller #(
        .DEBOUNCE_CYCLES(32'd4),
        .TICK_BASE(32'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(bs),
        .btn_mode(bm),
        .btn_speed(bsp),
        .led(led),
        .state(state),
        .mode(mode),
        .speed(speed)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int tt);
        while (cyc < tt) step();
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h want=00", led); end
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++;
        if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
        total++;
        if (speed !== 2'd0) begin bad++; $display("FAIL reset_speed got=%0d want=0", speed); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            bs = (i % 2 == 0);
            step();
            step();
        end
        bs = 1'b0;
        repeat (12) step();
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL bounce_state got=%0d want=0", state); end
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL bounce_led got=%h want=00", led); end
    endtask

    task automatic test_clean_start();
        c = cyc;
        bs = 1'b1;
        go(c + 7);
        t0 = cyc;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL start_state got=%0d want=1", state); end
        total++;
        if (led !== 8'h01) begin bad++; $display("FAIL start_led got=%h want=01", led); end
        go(c + 10);
        bs = 1'b0;
        go(t0 + 7);
        total++;
        if (led !== 8'h01) begin bad++; $display("FAIL start_led7 got=%h want=01", led); end
        go(t0 + 8);
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL start_led8 got=%h want=02", led); end
        go(t0 + 16);
        total++;
        if (led !== 8'h04) begin bad++; $display("FAIL start_led16 got=%h want=04", led); end
        go(t0 + 56);
        total++;
        if (led !== 8'h80) begin bad++; $display("FAIL start_led56 got=%h want=80", led); end
        go(t0 + 64);
        total++;
        if (led !== 8'h01) begin bad++; $display("FAIL start_wrap got=%h want=01", led); end
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL start_single got=%0d want=1", state); end
    endtask

    task automatic test_pause_resume();
        e = t0 + 72;
        go(e - 4);
        bs = 1'b1;
        go(e);
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL pause_pre got=%h want=02", led); end
        go(e + 3);
        bs = 1'b0;
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL pause_state got=%0d want=2", state); end
        go(e + 53);
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL pause_hold_state got=%0d want=2", state); end
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL pause_hold_led got=%h want=02", led); end
        bs = 1'b1;
        r = e + 60;
        go(r);
        bs = 1'b0;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL resume_state got=%0d want=1", state); end
        go(r + 4);
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL resume_r4 got=%h want=02", led); end
        go(r + 5);
        total++;
        if (led !== 8'h04) begin bad++; $display("FAIL resume_r5 got=%h want=04", led); end
        t = r + 5;
    endtask

    task automatic test_modes();
        bm = 1'b1;
        go(t + 7);
        m = cyc;
        bm = 1'b0;
        total++;
        if (mode !== 2'd1) begin bad++; $display("FAIL shr_mode got=%0d want=1", mode); end
        total++;
        if (led !== 8'h80) begin bad++; $display("FAIL shr_load got=%h want=80", led); end
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL shr_state got=%0d want=1", state); end
        go(m + 7);
        total++;
        if (led !== 8'h80) begin bad++; $display("FAIL shr_m7 got=%h want=80", led); end
        go(m + 8);
        total++;
        if (led !== 8'h40) begin bad++; $display("FAIL shr_m8 got=%h want=40", led); end
        go(m + 12);
        bm = 1'b1;
        go(m + 19);
        b = cyc;
        bm = 1'b0;
        total++;
        if (mode !== 2'd2) begin bad++; $display("FAIL bounce_mode got=%0d want=2", mode); end
        for (int k = 0; k < 16; k++) begin
            go(b + 8 * k);
            total++;
            if (led !== bounce_tab[k]) begin
                bad++;
                $display("FAIL bounce_seq k=%0d got=%h want=%h", k, led, bounce_tab[k]);
            end
        end
        bm = 1'b1;
        go(b + 127);
        kk = cyc;
        bm = 1'b0;
        total++;
        if (mode !== 2'd3) begin bad++; $display("FAIL blink_mode got=%0d want=3", mode); end
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL blink_load got=%h want=55", led); end
        go(kk + 7);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL blink_k7 got=%h want=55", led); end
        go(kk + 8);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL blink_k8 got=%h want=aa", led); end
        go(kk + 16);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL blink_k16 got=%h want=55", led); end
    endtask

    task automatic test_speed();
        bsp = 1'b1;
        go(kk + 23);
        s1 = cyc;
        bsp = 1'b0;
        total++;
        if (speed !== 2'd1) begin bad++; $display("FAIL speed1 got=%0d want=1", speed); end
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed1_led got=%h want=55", led); end
        go(s1 + 4);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed1_p4 got=%h want=aa", led); end
        go(s1 + 5);
        bsp = 1'b1;
        go(s1 + 8);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed1_p8 got=%h want=55", led); end
        go(s1 + 12);
        s2 = cyc;
        bsp = 1'b0;
        total++;
        if (speed !== 2'd2) begin bad++; $display("FAIL speed2 got=%0d want=2", speed); end
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed2_nostep got=%h want=55", led); end
        go(s2 + 2);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed2_p2 got=%h want=aa", led); end
        go(s2 + 4);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed2_p4 got=%h want=55", led); end
        go(s2 + 5);
        bsp = 1'b1;
        go(s2 + 10);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed2_p10 got=%h want=aa", led); end
        go(s2 + 12);
        s3 = cyc;
        bsp = 1'b0;
        total++;
        if (speed !== 2'd3) begin bad++; $display("FAIL speed3 got=%0d want=3", speed); end
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed3_nostep got=%h want=aa", led); end
        go(s3 + 1);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed3_c1 got=%h want=55", led); end
        go(s3 + 2);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed3_c2 got=%h want=aa", led); end
        go(s3 + 3);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed3_c3 got=%h want=55", led); end
        go(s3 + 5);
        bsp = 1'b1;
        go(s3 + 11);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed3_c11 got=%h want=55", led); end
        go(s3 + 12);
        s4 = cyc;
        bsp = 1'b0;
        total++;
        if (speed !== 2'd0) begin bad++; $display("FAIL speed_wrap got=%0d want=0", speed); end
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed0_nostep got=%h want=55", led); end
        go(s4 + 7);
        total++;
        if (led !== 8'h55) begin bad++; $display("FAIL speed0_p7 got=%h want=55", led); end
        go(s4 + 8);
        total++;
        if (led !== 8'hAA) begin bad++; $display("FAIL speed0_p8 got=%h want=aa", led); end
    endtask

    task automatic test_reset_mid_run();
        go(cyc + 3);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL arst_led got=%h want=00", led); end
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", state); end
        total++;
        if (mode !== 2'd0) begin bad++; $display("FAIL arst_mode got=%0d want=0", mode); end
        total++;
        if (speed !== 2'd0) begin bad++; $display("FAIL arst_speed got=%0d want=0", speed); end
        step();
        step();
        rst = 1'b0;
        step();
        c = cyc;
        bs = 1'b1;
        go(c + 7);
        bs = 1'b0;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL restart_state got=%0d want=1", state); end
        total++;
        if (led !== 8'h01) begin bad++; $display("FAIL restart_led got=%h want=01", led); end
        go(c + 15);
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL restart_step got=%h want=02", led); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_start();
        test_pause_resume();
        test_modes();
        test_speed();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
